// File: rtl/pe_stream_ctrl.sv
// pe_stream_ctrl: walks an instruction memory, streams operand addresses to parallel_pe
// and queues its results. Define PE_PERF_EN to add cyc_busy/cyc_hold cycle counters.
module pe_stream_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int INST_AW   = 2,
  parameter int ITER_W    = 8,
  parameter int RES_W     = 32,
  parameter int RES_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [INST_AW:0]   inst_num,
  output logic [INST_AW-1:0] inst_addr,
  input  logic [ITER_W-1:0]  inst_data,
  input  logic               hold,
  output logic [ADDR_W-1:0]  op_addr,
  output logic               pe_vld,
  output logic [1:0]         pe_ctl,
  input  logic               pe_vld_o,
  input  logic [RES_W-1:0]   pe_result,
  output logic               res_valid,
  output logic [RES_W-1:0]   res_data,
  input  logic               res_ready,
  output logic               busy,
  output logic               done
`ifdef PE_PERF_EN
  ,
  output logic [31:0]        cyc_busy,
  output logic [31:0]        cyc_hold
`endif
);
  localparam int PTR_W = $clog2(RES_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int NUM_W = INST_AW + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]         state, state_nxt;
  logic [INST_AW:0]   num;
  logic [ITER_W-1:0]  cnt, iter;
  logic [CNT_W-1:0]   outstanding, count, count_nxt;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [RES_W-1:0]   mem [RES_DEPTH];
  logic [OCC_W-1:0]   occupancy;
  logic               accept, issue, last_beat, last_inst, gate_ok;
  logic               push, pop, push_ok;

  assign accept     = (state == IDLE) && start;
  assign issue      = (state == STREAM) && !hold;
  assign last_beat  = (iter == cnt - ITER_W'(1));
  assign last_inst  = ({1'b0, inst_addr} == num - NUM_W'(1));
  // Results already promised plus results queued must leave room for one more.
  assign occupancy  = {1'b0, outstanding} + {1'b0, count};
  assign gate_ok    = occupancy < OCC_W'(RES_DEPTH);
  assign push       = pe_vld_o && (outstanding != '0);
  assign pop        = res_valid && res_ready;
  assign push_ok    = push && ((count != CNT_W'(RES_DEPTH)) || pop);
  assign rd_ptr_nxt = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (inst_num != '0) ? FETCH : DONE;
      FETCH:   if (gate_ok) state_nxt = LOAD;
      LOAD:    if (inst_data == '0) state_nxt = last_inst ? DRAIN : FETCH;
               else state_nxt = STREAM;
      STREAM:  if (issue && last_beat) state_nxt = last_inst ? DRAIN : FETCH;
      DRAIN:   if (outstanding == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop)      count_nxt = count + CNT_W'(1);
    else if (!push_ok && pop) count_nxt = count - CNT_W'(1);
  end

  // Issue stage: address out this cycle, operand and pe_vld/ctl appear next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      num         <= '0;
      inst_addr   <= '0;
      cnt         <= '0;
      iter        <= '0;
      op_addr     <= '0;
      pe_vld      <= 1'b0;
      pe_ctl      <= 2'b00;
      outstanding <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
      pe_vld <= issue;
      pe_ctl <= issue ? {last_beat, iter == '0} : 2'b00;
      if (accept) begin
        num       <= inst_num;
        inst_addr <= '0;
        op_addr   <= '0;
      end
      if (state == LOAD) begin
        cnt  <= inst_data;
        iter <= '0;
        if (inst_data == '0 && !last_inst) inst_addr <= inst_addr + INST_AW'(1);
      end
      if (issue) begin
        op_addr <= op_addr + ADDR_W'(1);
        iter    <= iter + ITER_W'(1);
        if (last_beat && !last_inst) inst_addr <= inst_addr + INST_AW'(1);
      end
      case ({issue && last_beat, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Result stage: head register mirrors the next FIFO head so outputs stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      count     <= count_nxt;
      rd_ptr    <= rd_ptr_nxt;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      res_valid <= (count_nxt != '0);
      res_data  <= (push_ok && wr_ptr == rd_ptr_nxt) ? pe_result : mem[rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= pe_result;
  end

`ifdef PE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cyc_busy <= '0;
      cyc_hold <= '0;
    end else begin
      if (busy && cyc_busy != 32'hFFFF_FFFF) cyc_busy <= cyc_busy + 32'd1;
      if (state == STREAM && hold && cyc_hold != 32'hFFFF_FFFF) cyc_hold <= cyc_hold + 32'd1;
    end
  end
`endif
endmodule
